// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divider latency, data width and the fdiv result-queue entry.
package fpu_pkg;

  localparam int unsigned FDIV_LAT  = 4;
  localparam int unsigned FP_W      = 32;
  // Room for up to 16 requesters; fdiv_sched narrows it to $clog2(NREQ).
  localparam int unsigned RESQ_ID_W = 4;

  typedef struct packed {
    logic [RESQ_ID_W-1:0] id;
    logic [FP_W-1:0]      y;
  } resq_entry_t;

endpackage

// File: rtl/fdiv_resq.sv
// Synchronous FIFO holding divider results until the consumer takes them.
// The writer never checks for space: it only pushes into a slot that was
// reserved beforehand, so a push into a full FIFO always has a pop beside it.
module fdiv_resq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_en_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy next-state; a pop is only honoured when data exists.
  always_comb begin
    pop_en_c = pop_i & valid_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_en_c);
    if (push_i) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_en_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fdiv_sched.sv
// Shares one pipelined, non-stallable fdiv unit between NREQ requesters:
// round-robin grant, id tracking across the divider latency and a
// credit-protected result queue so consumer back-pressure never drops data.
module fdiv_sched
  import fpu_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned LAT    = FDIV_LAT,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [FP_W*NREQ-1:0]      req_x1,
  input  logic [FP_W*NREQ-1:0]      req_x2,
  output logic [FP_W-1:0]           div_x1,
  output logic [FP_W-1:0]           div_x2,
  input  logic [FP_W-1:0]           div_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [FP_W-1:0]           rsp_y,
  output logic                      busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(QDEPTH + 1);
  localparam int unsigned SW  = CW + 1;

  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0]          vld_q, vld_d;
  logic [LAT-1:0][IDW-1:0] id_q, id_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           qcount;

  logic                    credit_ok_c;
  logic                    grant_c;
  logic [IDW-1:0]          gidx_c;
  logic [IDW-1:0]          cand_c;
  logic                    capture_c;
  logic                    pop_c;
  resq_entry_t             push_entry_c;
  resq_entry_t             head_c;

  // Credit check and round-robin search from rr_ptr; reset forces no grant.
  always_comb begin
    grant_c     = 1'b0;
    gidx_c      = '0;
    cand_c      = '0;
    req_ready   = '0;
    credit_ok_c = (SW'(inflight_q) + SW'(qcount)) < SW'(QDEPTH);
    if (rstn && credit_ok_c) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand_c = IDW'((32'(rr_ptr_q) + k) % NREQ);
        if (!grant_c && req_valid[cand_c]) begin
          grant_c = 1'b1;
          gidx_c  = cand_c;
        end
      end
    end
    if (grant_c) begin
      req_ready[gidx_c] = 1'b1;
    end
  end

  // Granted operands go straight to the divider; zeros when idle.
  always_comb begin
    div_x1 = '0;
    div_x2 = '0;
    if (grant_c) begin
      div_x1 = req_x1[FP_W*gidx_c +: FP_W];
      div_x2 = req_x2[FP_W*gidx_c +: FP_W];
    end
  end

  // Pointer advance past the winner, id shift register and in-flight count.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    vld_d      = '0;
    id_d       = '0;
    capture_c  = vld_q[LAT-1];
    inflight_d = inflight_q + CW'(grant_c) - CW'(capture_c);
    if (grant_c) begin
      rr_ptr_d = (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + IDW'(1);
    end
    vld_d[0] = grant_c;
    id_d[0]  = gidx_c;
    for (int unsigned s = 1; s < LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s]  = id_q[s-1];
    end
  end

  // Arbiter and pipeline state; reset discards everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q   <= '0;
      vld_q      <= '0;
      id_q       <= '0;
      inflight_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      vld_q      <= vld_d;
      id_q       <= id_d;
      inflight_q <= inflight_d;
    end
  end

  // Result emerging from the divider, tagged with the id that travelled alongside it.
  always_comb begin
    push_entry_c    = '0;
    push_entry_c.id = RESQ_ID_W'(id_q[LAT-1]);
    push_entry_c.y  = div_y;
  end

  assign pop_c = rsp_valid & rsp_ready;

  fdiv_resq #(
    .DEPTH (QDEPTH),
    .W     ($bits(resq_entry_t))
  ) u_resq (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (capture_c),
    .push_data_i (push_entry_c),
    .pop_i       (pop_c),
    .head_o      (head_c),
    .valid_o     (rsp_valid),
    .count_o     (qcount)
  );

  assign rsp_y  = head_c.y;
  assign rsp_id = IDW'(head_c.id);
  assign busy   = (inflight_q != '0) | (qcount != '0);

endmodule

// File: tb/tb_fdiv_sched.sv
// Self-checking bench for fdiv_sched: directed scenarios plus random traffic,
// compared each cycle against a transaction-level reference model.
module tb_fdiv_sched;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned LAT    = 4;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned IDW    = 1;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_x1;
  logic [32*NREQ-1:0]   req_x2;
  logic [31:0]          div_x1;
  logic [31:0]          div_x2;
  logic [31:0]          div_y;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_y;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  fdiv_sched #(
    .NREQ   (NREQ),
    .LAT    (LAT),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .div_x1    (div_x1),
    .div_x2    (div_x2),
    .div_y     (div_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in quotient: exact for the directed IEEE cases, a bit scramble otherwise.
  function automatic logic [31:0] fdiv_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h3F80_0000 && b == 32'h4080_0000) return 32'h3E80_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
  endfunction

  // External divider: LAT-cycle pipeline.
  logic [31:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= fdiv_fn(div_x1, div_x2);
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_y = dpipe[LAT-1];

  // Reference model: list of outstanding ops (issued, not yet consumed) in issue order.
  typedef struct {
    int          id;
    logic [31:0] y;
    int          due;
  } op_t;

  op_t         pend[$];
  int          rr;
  int          cyc;
  int          obs_g;
  logic        obs_rv;
  logic [31:0] obs_y;
  int          obs_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (rstn !== 1'b1 || pend.size() >= QDEPTH) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i = (rr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_x1[32*i +: 32] = a;
    req_x2[32*i +: 32] = b;
  endtask

  // One cycle: check outputs mid-cycle, then advance the model past the edge.
  task automatic tick();
    logic [NREQ-1:0] er;
    logic [31:0]     ex1;
    logic [31:0]     ex2;
    logic            erv;
    int              eg;
    #3;
    if (rstn !== 1'b1) begin
      pend.delete();
      rr = 0;
    end
    eg  = model_grant();
    er  = '0;
    ex1 = '0;
    ex2 = '0;
    if (eg >= 0) begin
      er[eg] = 1'b1;
      ex1    = req_x1[32*eg +: 32];
      ex2    = req_x2[32*eg +: 32];
    end
    erv = (pend.size() > 0) && (pend[0].due <= cyc);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("div_x1", 64'(div_x1), 64'(ex1));
    chk("div_x2", 64'(div_x2), 64'(ex2));
    chk("rsp_valid", 64'(rsp_valid), 64'(erv));
    chk("busy", 64'(busy), 64'(pend.size() > 0));
    if (erv) begin
      chk("rsp_id", 64'(rsp_id), 64'(pend[0].id));
      chk("rsp_y", 64'(rsp_y), 64'(pend[0].y));
    end
    obs_g = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i] && req_valid[i]) obs_g = i;
    obs_rv = rsp_valid;
    obs_y  = rsp_y;
    obs_id = int'(rsp_id);
    @(posedge clk);
    #1;
    if (rstn === 1'b1) begin
      if (erv && rsp_ready) void'(pend.pop_front());
      if (eg >= 0) begin
        pend.push_back('{id: eg, y: fdiv_fn(ex1, ex2), due: cyc + LAT + 1});
        rr = (eg + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (pend.size() == 0) break;
      tick();
    end
    tick();
    chk("drain_busy", 64'(busy), 64'(0));
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    int          lat;
    int          ng;
    int          pops;
    int          cnt;
    int          gseq[$];
    int          rid[$];
    logic [31:0] ry[$];

    rstn      = 1'b0;
    req_valid = '0;
    req_x1    = '0;
    req_x2    = '0;
    rsp_ready = 1'b0;
    rr        = 0;
    cyc       = 0;
    #1;
    req_valid = 2'b11;
    repeat (2) tick();
    req_valid = '0;
    rstn      = 1'b1;
    repeat (2) tick();

    // Single op on requester 0, latency and quotient
    rsp_ready = 1'b1;
    set_op(0, 32'h40C0_0000, 32'h4000_0000);
    req_valid = 2'b01;
    tick();
    chk("t1_grant", 64'(obs_g), 64'(0));
    req_valid = '0;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (obs_rv) begin
        lat = n;
        break;
      end
    end
    chk("t1_latency", 64'(lat), 64'(LAT + 1));
    chk("t1_y", 64'(obs_y), 64'(32'h4040_0000));
    chk("t1_id", 64'(obs_id), 64'(0));
    drain();

    // Both requesters valid: alternating grants, in-order results
    reset_pulse();
    set_op(0, 32'h40C0_0000, 32'h4000_0000);
    set_op(1, 32'h3F80_0000, 32'h4080_0000);
    req_valid = 2'b11;
    gseq.delete();
    rid.delete();
    ry.delete();
    for (int n = 0; n < 16; n++) begin
      tick();
      if (obs_g >= 0) gseq.push_back(obs_g);
      if (obs_rv) begin
        rid.push_back(obs_id);
        ry.push_back(obs_y);
      end
    end
    chk("t2_ngrants", 64'(gseq.size() >= 6), 64'(1));
    for (int k = 0; k < 6 && k < gseq.size(); k++) chk("t2_alt", 64'(gseq[k]), 64'(k % 2));
    chk("t2_nrsp", 64'(rid.size() >= 2), 64'(1));
    if (rid.size() >= 2) begin
      chk("t2_rsp0_id", 64'(rid[0]), 64'(0));
      chk("t2_rsp0_y", 64'(ry[0]), 64'(32'h4040_0000));
      chk("t2_rsp1_id", 64'(rid[1]), 64'(1));
      chk("t2_rsp1_y", 64'(ry[1]), 64'(32'h3E80_0000));
    end
    drain();

    // Stalled consumer: exactly QDEPTH grants, then no more
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    set_op(0, $urandom, $urandom);
    set_op(1, $urandom, $urandom);
    ng = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (obs_g >= 0) ng++;
    end
    chk("t3_grants", 64'(ng), 64'(QDEPTH));
    chk("t3_ready_low", 64'(req_ready), 64'(0));

    // Release slowly: a pop frees a credit, refill pushes beside pops
    pops = 0;
    for (int n = 0; n < 30; n++) begin
      rsp_ready = ((n % 4) == 0) || ((n % 4) == 3);
      set_op(n % 2, $urandom, $urandom);
      tick();
      if (obs_g >= 0) ng++;
      if (obs_rv && rsp_ready) pops++;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 40 && pend.size() != 0; n++) begin
      tick();
      if (obs_rv) pops++;
    end
    chk("t34_no_loss", 64'(pops), 64'(ng));
    drain();

    // Reset with three ops in flight
    reset_pulse();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    repeat (3) tick();
    req_valid = '0;
    rstn      = 1'b0;
    tick();
    chk("t5_rsp_valid", 64'(obs_rv), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    rstn = 1'b1;
    cnt  = 0;
    for (int n = 0; n < LAT + 4; n++) begin
      tick();
      if (obs_rv) cnt++;
    end
    chk("t5_stale", 64'(cnt), 64'(0));
    req_valid = 2'b11;
    tick();
    chk("t5_rr_zero", 64'(obs_g), 64'(0));
    drain();

    // Only requester 1 active: five grants to id 1, pointer back at 0
    reset_pulse();
    rsp_ready = 1'b1;
    req_valid = 2'b10;
    ng = 0;
    for (int n = 0; n < 30 && ng < 5; n++) begin
      set_op(1, $urandom, $urandom);
      tick();
      if (obs_g >= 0) begin
        ng++;
        chk("t6_gid", 64'(obs_g), 64'(1));
      end
    end
    chk("t6_count", 64'(ng), 64'(5));
    drain();
    req_valid = 2'b11;
    tick();
    chk("t6_rr_end", 64'(obs_g), 64'(0));
    drain();

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      set_op(0, $urandom, $urandom);
      set_op(1, $urandom, $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rstn      = ($urandom_range(0, 99) != 0);
      tick();
    end
    rstn = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
